// File: rtl/rv_branch_pkg.sv
// ============================================================================
//  Module      : rv_branch_pkg
//  Description : Shared branch encodings and 2-bit bimodal counter helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] SNT      = 2'b00;
    localparam logic [1:0] WNT      = 2'b01;
    localparam logic [1:0] WT       = 2'b10;
    localparam logic [1:0] ST       = 2'b11;
    localparam logic [1:0] BHT_INIT = WNT;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            ctr_next = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            ctr_next = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
//  Module      : branch_resolve_unit_if
//  Description : EX branch request, IF lookup and resolved-result bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             ex_valid_i;
    logic [2:0]       ex_funct3_i;
    logic [XLEN-1:0]  ex_rs1_i;
    logic [XLEN-1:0]  ex_rs2_i;
    logic [XLEN-1:0]  ex_pc_i;
    logic [XLEN-1:0]  ex_imm_i;
    logic             ex_pred_i;
    logic             stall_i;
    logic             flush_i;
    logic [XLEN-1:0]  if_pc_i;
    logic             if_pred_o;
    logic             res_valid_o;
    logic             res_taken_o;
    logic             res_mispred_o;
    logic [XLEN-1:0]  res_target_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output ex_valid_i, ex_funct3_i, ex_rs1_i, ex_rs2_i, ex_pc_i, ex_imm_i,
               ex_pred_i, stall_i, flush_i, if_pc_i,
        input  if_pred_o, res_valid_o, res_taken_o, res_mispred_o, res_target_o,
               branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  ex_valid_i, ex_funct3_i, ex_rs1_i, ex_rs2_i, ex_pc_i, ex_imm_i,
               ex_pred_i, stall_i, flush_i, if_pc_i,
        output if_pred_o, res_valid_o, res_taken_o, res_mispred_o, res_target_o,
               branch_cnt_o, mispred_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/bht_bimodal.sv
// ============================================================================
//  Module      : bht_bimodal
//  Description : DEPTH-entry 2-bit saturating counter table, one lookup port
//                and one update port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_bimodal
    import rv_branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_pred,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= BHT_INIT;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
        end
    end

    // Read is combinational off the stored array, so a same-cycle update
    // to the looked-up entry is only visible after the edge.
    assign lookup_pred = (ctr[lookup_idx] >= WT);

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : EX-stage branch resolver: registered compare/target result,
//                bimodal BHT training with IF lookup, perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
    import rv_branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    logic            cmp_eq;
    logic            cmp_lt_s;
    logic            cmp_lt_u;
    logic            taken;
    logic            mispred;
    logic [XLEN-1:0] target;
    logic            load;
    logic            train;

    logic             res_valid;
    logic             res_taken;
    logic             res_mispred;
    logic [XLEN-1:0]  res_target;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    always_comb begin
        cmp_eq   = (bus.ex_rs1_i == bus.ex_rs2_i);
        cmp_lt_s = ($signed(bus.ex_rs1_i) < $signed(bus.ex_rs2_i));
        cmp_lt_u = (bus.ex_rs1_i < bus.ex_rs2_i);
        taken    = 1'b0;
        case (bus.ex_funct3_i)
            BR_BEQ:  taken = cmp_eq;
            BR_BNE:  taken = !cmp_eq;
            BR_BLT:  taken = cmp_lt_s;
            BR_BGE:  taken = !cmp_lt_s;
            BR_BLTU: taken = cmp_lt_u;
            BR_BGEU: taken = !cmp_lt_u;
            default: taken = 1'b0;
        endcase
    end

    assign target  = taken ? (bus.ex_pc_i + bus.ex_imm_i) : (bus.ex_pc_i + XLEN'(4));
    assign mispred = (taken != bus.ex_pred_i);
    assign load    = !bus.flush_i && !bus.stall_i;
    // Training is tied to the loading edge so a stalled result is counted once.
    assign train   = load && bus.ex_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_mispred <= 1'b0;
            res_target  <= '0;
        end else if (bus.flush_i) begin
            res_valid   <= 1'b0;
        end else if (load) begin
            res_valid   <= bus.ex_valid_i;
            res_taken   <= taken;
            res_mispred <= mispred;
            res_target  <= target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (train) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispred && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

    logic if_pred;

    bht_bimodal #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_idx  (bus.if_pc_i[IDX_W+1:2]),
        .lookup_pred (if_pred),
        .upd_en      (train),
        .upd_idx     (bus.ex_pc_i[IDX_W+1:2]),
        .upd_taken   (taken)
    );

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, bus.if_pc_i[1:0], bus.if_pc_i[XLEN-1:IDX_W+2],
                              bus.ex_pc_i[1:0], bus.ex_pc_i[XLEN-1:IDX_W+2]};

    assign bus.if_pred_o     = if_pred;
    assign bus.res_valid_o   = res_valid;
    assign bus.res_taken_o   = res_taken;
    assign bus.res_mispred_o = res_mispred;
    assign bus.res_target_o  = res_target;
    assign bus.branch_cnt_o  = branch_cnt;
    assign bus.mispred_cnt_o = mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Scoreboard bench for branch_resolve_unit with random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

    logic clk;
    logic rst_n;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

    branch_resolve_unit #(.XLEN(32), .DEPTH(64), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          taken;
        bit          mispred;
        logic [31:0] target;
        longint      bc;
        longint      mc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference state: the architectural view of the result stage.
    bit          m_valid;
    bit          m_taken;
    bit          m_mispred;
    logic [31:0] m_target;
    longint      m_bc;
    longint      m_mc;
    int          m_bht[64];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int     sa = a;
        int     sb_ = b;
        longint ua = a;
        longint ub = b;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb_;
            3'd5:    return sa >= sb_;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_taken = 0; m_mispred = 0; m_target = '0;
        m_bc = 0; m_mc = 0;
        foreach (m_bht[i]) m_bht[i] = 1;
        sb.delete();
    endtask

    task automatic model_edge(input bit v, input logic [2:0] f3, input logic [31:0] a, b, pc, imm,
                              input bit pred, input bit st, input bit fl);
        bit t;
        int idx;
        exp_t e;
        if (fl) begin
            m_valid = 0;
        end else if (!st) begin
            t         = ref_taken(f3, a, b);
            m_valid   = v;
            m_taken   = t;
            m_mispred = (t != pred);
            m_target  = t ? pc + imm : pc + 32'd4;
            if (v) begin
                idx = int'(pc[7:2]);
                if (t && m_bht[idx] < 3) m_bht[idx]++;
                if (!t && m_bht[idx] > 0) m_bht[idx]--;
                if (m_bc < 64'hFFFF_FFFF) m_bc++;
                if (m_mispred && m_mc < 64'hFFFF_FFFF) m_mc++;
            end
        end
        if (m_valid) begin
            e.taken = m_taken; e.mispred = m_mispred; e.target = m_target;
            e.bc = m_bc; e.mc = m_mc;
            sb.push_back(e);
        end
    endtask

    task automatic step(input bit v, input logic [2:0] f3, input logic [31:0] a, b, pc, imm,
                        input bit pred, input bit st, input bit fl);
        bus.ex_valid_i  = v;
        bus.ex_funct3_i = f3;
        bus.ex_rs1_i    = a;
        bus.ex_rs2_i    = b;
        bus.ex_pc_i     = pc;
        bus.ex_imm_i    = imm;
        bus.ex_pred_i   = pred;
        bus.stall_i     = st;
        bus.flush_i     = fl;
        @(posedge clk);
        model_edge(v, f3, a, b, pc, imm, pred, st, fl);
        #1;
    endtask

    task automatic check_pred(input string nm, input logic [31:0] pc);
        bus.if_pc_i = pc;
        #1;
        chk(nm, longint'(bus.if_pred_o), longint'(m_bht[int'(pc[7:2])] >= 2));
    endtask

    // Monitor: pops one expectation per cycle the DUT shows a valid result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.res_valid_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_taken",   longint'(bus.res_taken_o),   longint'(e.taken));
                        chk("res_mispred", longint'(bus.res_mispred_o), longint'(e.mispred));
                        chk("res_target",  longint'(bus.res_target_o),  longint'(e.target));
                        chk("branch_cnt",  longint'(bus.branch_cnt_o),  e.bc);
                        chk("mispred_cnt", longint'(bus.mispred_cnt_o), e.mc);
                    end
                end else if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("missing_valid", 0, 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] specials [5];
        logic [31:0] a, b, pc, imm;
        logic [2:0]  f3;
        longint      bc_before;
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        rst_n = 1'b0;
        model_reset();
        step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        bus.if_pc_i = 32'h0;
        #1;
        chk("rst_valid",   longint'(bus.res_valid_o),   0);
        chk("rst_taken",   longint'(bus.res_taken_o),   0);
        chk("rst_target",  longint'(bus.res_target_o),  0);
        chk("rst_bcnt",    longint'(bus.branch_cnt_o),  0);
        chk("rst_mcnt",    longint'(bus.mispred_cnt_o), 0);
        chk("rst_if_pred", longint'(bus.if_pred_o),     0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Target wrap with negative immediate; first mispredict.
        step(1, 3'd0, 32'd7, 32'd7, 32'h100, 32'hFFFF_FFF0, 0, 0, 0);
        chk("t2_valid",  longint'(bus.res_valid_o),   1);
        chk("t2_target", longint'(bus.res_target_o),  32'hF0);
        chk("t2_mcnt",   longint'(bus.mispred_cnt_o), 1);

        // Signedness and >= boundaries.
        step(1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'd64, 1, 0, 0);
        chk("t1_blt", longint'(bus.res_taken_o), 1);
        step(1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'd64, 1, 0, 0);
        chk("t1_bltu", longint'(bus.res_taken_o), 0);
        step(1, 3'd5, 32'd5, 32'd5, 32'h208, 32'd64, 0, 0, 0);
        chk("t1_bge", longint'(bus.res_taken_o), 1);
        step(1, 3'd7, 32'd5, 32'd5, 32'h20C, 32'd64, 0, 0, 0);
        chk("t1_bgeu", longint'(bus.res_taken_o), 1);
        step(1, 3'd2, 32'd5, 32'd5, 32'h210, 32'd64, 1, 0, 0);
        chk("funct3_010", longint'(bus.res_mispred_o), 1);

        // PC+4 wraps to zero.
        step(1, 3'd1, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'd100, 0, 0, 0);
        chk("t3_wrap", longint'(bus.res_target_o), 0);

        // Same PC taken back to back: 01 -> 10 -> 11 -> 11.
        check_pred("t4_pre", 32'h340);
        for (int i = 0; i < 3; i++) begin
            step(1, 3'd0, 32'd9, 32'd9, 32'h340, 32'd8, 0, 0, 0);
            check_pred("t4_pred", 32'h340);
        end
        chk("t4_ctr", longint'(m_bht[16]), 3);

        // Stall holds the result and counts it once; flush beats stall.
        bc_before = m_bc;
        step(1, 3'd1, 32'd1, 32'd2, 32'h400, 32'd32, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 3'd0, 32'd4, 32'd4, 32'h500, 32'd12, 0, 1, 0);
            chk("t5_held_target", longint'(bus.res_target_o), 32'h420);
        end
        chk("t5_bcnt", longint'(bus.branch_cnt_o), bc_before + 1);
        step(1, 3'd0, 32'd4, 32'd4, 32'h500, 32'd12, 0, 1, 1);
        chk("t5_flush", longint'(bus.res_valid_o), 0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: begin a = $urandom; b = a; end
                1: begin a = $urandom; b = $urandom; end
                default: begin
                    a = specials[$urandom_range(0, 4)];
                    b = specials[$urandom_range(0, 4)];
                end
            endcase
            pc  = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_FC00;
            imm = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
            check_pred("rnd_if_pred", 32'($urandom_range(0, 255)) << 2);
            step($urandom_range(0, 9) < 8, f3, a, b, pc, imm, 1'($urandom),
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
        end

        // Asynchronous reset in the middle of a result.
        step(1, 3'd0, 32'd1, 32'd1, 32'h10, 32'd16, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_valid", longint'(bus.res_valid_o),   0);
        chk("t6_bcnt",  longint'(bus.branch_cnt_o),  0);
        chk("t6_mcnt",  longint'(bus.mispred_cnt_o), 0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        bus.ex_valid_i = 0; bus.stall_i = 0; bus.flush_i = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            check_pred("t6_bht", 32'(i) << 2);
        end

        @(negedge clk); #1;
        chk("sb_drain", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
